// File: rtl/load_sequencer_pkg.sv
// Shared definitions for the load sequencer and the counter bench.
// Contents:
//   DEFAULT_WIDTH - default preset / counter / terminal width
//   DEFAULT_DEPTH - default preset queue depth (power of two, >= 2)
//   seq_state_t   - sequencer FSM state encoding
package load_sequencer_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    STARVE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/load_sequencer_preset_fifo.sv
// preset_fifo: synchronous FIFO holding presets for the load sequencer.
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-low reset, empties the queue
//   push  - write request (ignored when full)
//   wdata - value to write
//   pop   - read request (ignored when empty)
//   rdata - head entry, valid while !empty
//   full  - queue holds DEPTH entries
//   empty - queue holds no entries
//   level - number of entries held
module preset_fifo
  import load_sequencer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // The head is read from storage, so an entry written on an edge is only
  // visible from the next cycle: there is no same-cycle push-through.
  assign rdata = mem[rd_ptr];

  // Storage needs no reset; the pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/load_sequencer.sv
// load_sequencer: upstream control stage for a loadable up-counter.
// Queues presets from a producer and issues load strobes to the counter:
// the first preset on enable, later ones when the counter reaches term.
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-low reset
//   enable   - sequencer enable; no loads while low
//   in_valid - producer presents a preset
//   in_ready - queue can accept a preset (!full)
//   in_data  - preset value
//   term     - terminal count that triggers a reload
//   q        - counter value fed back from the counter
//   load     - registered load strobe to the counter
//   data_out - registered preset for the counter's data_in
//   underrun - one-cycle pulse: reload due with an empty queue
//   level    - number of queued presets
module load_sequencer
  import load_sequencer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] term,
  input  logic [WIDTH-1:0] q,
  output logic             load,
  output logic [WIDTH-1:0] data_out,
  output logic             underrun,
  output logic [LW-1:0]    level
);

  seq_state_t       state;
  seq_state_t       next_state;
  logic             full;
  logic             empty;
  logic [WIDTH-1:0] head;
  logic             do_pop;
  logic             underrun_next;
  logic             match;

  assign in_ready = !full;

  preset_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .wdata (in_data),
    .pop   (do_pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // During a load cycle the counter still shows term+1 of the old run, so
  // comparisons are suppressed; this also keeps load from firing twice in a row.
  assign match = (q == term) && !load;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Every pop is gated by !load so strobes can never land on adjacent cycles,
  // even if enable toggles right after a load.
  always_comb begin
    next_state    = state;
    do_pop        = 1'b0;
    underrun_next = 1'b0;
    case (state)
      IDLE: begin
        if (enable && !empty && !load) begin
          do_pop     = 1'b1;
          next_state = RUN;
        end
      end
      RUN: begin
        if (!enable) begin
          next_state = IDLE;
        end else if (match && !empty) begin
          do_pop = 1'b1;
        end else if (match) begin
          underrun_next = 1'b1;
          next_state    = STARVE;
        end
      end
      STARVE: begin
        if (!enable) begin
          next_state = IDLE;
        end else if (!empty && !load) begin
          do_pop     = 1'b1;
          next_state = RUN;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // data_out captures the head on the popping edge and holds it otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load     <= 1'b0;
      data_out <= '0;
      underrun <= 1'b0;
    end else begin
      load     <= do_pop;
      underrun <= underrun_next;
      if (do_pop) begin
        data_out <= head;
      end
    end
  end

endmodule

// File: tb/tb_load_sequencer.sv
// Directed self-checking bench for load_sequencer with a behavioural
// loadable up-counter closing the q feedback loop.
module tb_load_sequencer;
  import load_sequencer_pkg::*;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic [3:0] term;
  logic [3:0] q;
  logic       load;
  logic [3:0] data_out;
  logic       underrun;
  logic [2:0] level;

  logic       use_model;
  logic [3:0] q_manual;
  logic [3:0] cnt;

  int errors = 0;
  int checks = 0;

  load_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .term     (term),
    .q        (q),
    .load     (load),
    .data_out (data_out),
    .underrun (underrun),
    .level    (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counter model: loads data_out when load is high, otherwise counts up.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= data_out;
    end else begin
      cnt <= cnt + 4'd1;
    end
  end

  assign q = use_model ? cnt : q_manual;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    rst       = 1'b0;
    enable    = 1'b0;
    in_valid  = 1'b0;
    in_data   = 4'd0;
    use_model = 1'b1;
    q_manual  = 4'd0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic apply_stimulus(input logic [3:0] value);
    in_valid = 1'b1;
    in_data  = value;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_q [6];
    logic [3:0] exp_ld [4];
    int ld_idx;
    int ld_cyc [4];
    int bad_load;
    int bad_under;

    term = 4'd15;

    // Reset state
    rst       = 1'b0;
    enable    = 1'b0;
    in_valid  = 1'b0;
    in_data   = 4'd0;
    use_model = 1'b1;
    q_manual  = 4'd0;
    #3;
    check_output("rst_load", 8'(load), 8'd0);
    check_output("rst_data_out", 8'(data_out), 8'd0);
    check_output("rst_underrun", 8'(underrun), 8'd0);
    check_output("rst_level", 8'(level), 8'd0);
    check_output("rst_in_ready", 8'(in_ready), 8'd1);
    check_output("rst_state", 8'(dut.state), 8'(IDLE));

    // Single preset loads on enable
    $display("[TB] single preset");
    apply_reset();
    term   = 4'd15;
    enable = 1'b1;
    apply_stimulus(4'd4);
    check_output("t1_level_after_push", 8'(level), 8'd1);
    check_output("t1_no_early_load", 8'(load), 8'd0);
    step();
    check_output("t1_load", 8'(load), 8'd1);
    check_output("t1_data_out", 8'(data_out), 8'd4);
    check_output("t1_level_empty", 8'(level), 8'd0);
    step();
    check_output("t1_load_one_cycle", 8'(load), 8'd0);
    check_output("t1_q", 8'(q), 8'd4);
    check_output("t1_data_hold", 8'(data_out), 8'd4);

    // Reload on terminal match
    $display("[TB] reload at term");
    apply_reset();
    term = 4'd7;
    apply_stimulus(4'd4);
    apply_stimulus(4'd10);
    check_output("t2_level", 8'(level), 8'd2);
    enable = 1'b1;
    step();
    check_output("t2_first_load", 8'(load), 8'd1);
    check_output("t2_first_data", 8'(data_out), 8'd4);
    exp_q = '{4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd10};
    for (int i = 0; i < 6; i++) begin
      step();
      check_output($sformatf("t2_q%0d", i), 8'(q), 8'(exp_q[i]));
      check_output($sformatf("t2_load%0d", i), 8'(load), (i == 4) ? 8'd1 : 8'd0);
    end
    check_output("t2_data_out", 8'(data_out), 8'd10);
    check_output("t2_level_end", 8'(level), 8'd0);

    // Underrun then recovery from STARVE
    $display("[TB] underrun");
    apply_reset();
    term = 4'd7;
    apply_stimulus(4'd4);
    enable = 1'b1;
    step();
    check_output("t3_load", 8'(load), 8'd1);
    step();
    step();
    step();
    step();
    check_output("t3_q_term", 8'(q), 8'd7);
    check_output("t3_no_under_yet", 8'(underrun), 8'd0);
    step();
    check_output("t3_underrun", 8'(underrun), 8'd1);
    check_output("t3_q8", 8'(q), 8'd8);
    check_output("t3_no_load", 8'(load), 8'd0);
    check_output("t3_state_starve", 8'(dut.state), 8'(STARVE));
    step();
    check_output("t3_underrun_pulse", 8'(underrun), 8'd0);
    check_output("t3_q9", 8'(q), 8'd9);
    apply_stimulus(4'd2);
    check_output("t3_level1", 8'(level), 8'd1);
    check_output("t3_no_pushthrough", 8'(load), 8'd0);
    step();
    check_output("t3_reload", 8'(load), 8'd1);
    check_output("t3_reload_data", 8'(data_out), 8'd2);
    step();
    check_output("t3_q_new", 8'(q), 8'd2);

    // Full queue, then drain in order
    $display("[TB] full queue");
    apply_reset();
    term = 4'd3;
    apply_stimulus(4'd1);
    apply_stimulus(4'd2);
    apply_stimulus(4'd3);
    apply_stimulus(4'd4);
    check_output("t4_level_full", 8'(level), 8'd4);
    check_output("t4_in_ready_low", 8'(in_ready), 8'd0);
    apply_stimulus(4'd5);
    check_output("t4_level_no_overflow", 8'(level), 8'd4);
    enable = 1'b1;
    exp_ld = '{4'd1, 4'd2, 4'd3, 4'd4};
    ld_idx = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (load) begin
        if (ld_idx < 4) begin
          check_output($sformatf("t4_load_val%0d", ld_idx), 8'(data_out), 8'(exp_ld[ld_idx]));
          ld_cyc[ld_idx] = c;
        end
        ld_idx++;
      end
    end
    check_output("t4_load_count", 8'(ld_idx), 8'd4);
    if (ld_idx >= 4) begin
      check_output("t4_gap_2_3", 8'(ld_cyc[2] - ld_cyc[1]), 8'd3);
      check_output("t4_gap_preset_eq_term", 8'(ld_cyc[3] - ld_cyc[2]), 8'd2);
    end
    check_output("t4_level_drained", 8'(level), 8'd0);

    // Asynchronous reset while load is high
    $display("[TB] async reset");
    apply_reset();
    term = 4'd7;
    apply_stimulus(4'd4);
    apply_stimulus(4'd9);
    enable = 1'b1;
    step();
    check_output("t5_load_before", 8'(load), 8'd1);
    #2;
    rst = 1'b0;
    #1;
    check_output("t5_load_async", 8'(load), 8'd0);
    check_output("t5_level_async", 8'(level), 8'd0);
    check_output("t5_in_ready_rst", 8'(in_ready), 8'd1);
    @(negedge clk);
    rst = 1'b1;
    bad_load  = 0;
    bad_under = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (load) bad_load++;
      if (underrun) bad_under++;
    end
    check_output("t5_no_loads", 8'(bad_load), 8'd0);
    check_output("t5_no_underruns", 8'(bad_under), 8'd0);

    // Disable in RUN, then terminal match with queued entries
    $display("[TB] disable in run");
    apply_reset();
    term = 4'd7;
    apply_stimulus(4'd4);
    apply_stimulus(4'd9);
    apply_stimulus(4'd12);
    enable = 1'b1;
    step();
    check_output("t6_load", 8'(load), 8'd1);
    check_output("t6_level2", 8'(level), 8'd2);
    enable    = 1'b0;
    use_model = 1'b0;
    q_manual  = 4'd7;
    step();
    check_output("t6_load_off", 8'(load), 8'd0);
    step();
    step();
    check_output("t6_no_load", 8'(load), 8'd0);
    check_output("t6_no_underrun", 8'(underrun), 8'd0);
    check_output("t6_level_kept", 8'(level), 8'd2);
    check_output("t6_state_idle", 8'(dut.state), 8'(IDLE));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_sequencer.md
Name: load_sequencer

Overview:
- Upstream control stage for the 4-bit loadable up-counter.
- Buffers a queue of preset values from a producer through a valid/ready interface.
- Drives the counter's load/data_in pair: the first preset loads on enable, and each later preset loads when the counter output reaches a programmable terminal value.
- Flags an underrun when a reload is due but the queue is empty.

Parameters:
- WIDTH, 4, bit width of presets, counter value and terminal value.
- DEPTH, 4, preset queue depth in entries; power of two, at least 2.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset; asynchronous, active-low (asserted at 0).
- enable  input  1  sequencer enable; when 0, no loads are issued.
- in_valid  input  1  producer presents a preset.
- in_ready  output  1  queue can accept a preset; equals !full.
- in_data  input  WIDTH  preset value.
- term  input  WIDTH  terminal count that triggers a reload.
- q  input  WIDTH  current counter value, fed back from the counter.
- load  output  1  load strobe to the counter; registered.
- data_out  output  WIDTH  preset to the counter's data_in; registered.
- underrun  output  1  one-cycle pulse: reload due while the queue is empty.
- level  output  $clog2(DEPTH+1)  number of queued entries.

Behaviour:
- Reset (rst=0, asynchronous):
  - load=0, data_out=0, underrun=0, level=0.
  - Queue pointers cleared; all queued entries are discarded.
  - State=IDLE.
  - in_ready=1 while in reset.
- Push:
  - Occurs on an edge where in_valid && in_ready; level increments on that edge.
  - A pushed entry is poppable from the following cycle onward; no same-cycle push-through.
- Pop:
  - Occurs on the edge that sets load=1; data_out takes the head entry on that edge.
  - Simultaneous push and pop: level unchanged; both take effect.
- match = (q == term) && !load. A match is ignored in any cycle where load=1.
- FSM states: IDLE, RUN, STARVE.
  - IDLE:
    - If enable && level!=0: set load=1 and data_out=head on the next edge, pop, go to RUN.
    - Otherwise stay in IDLE.
  - RUN:
    - If !enable: go to IDLE; no load is issued.
    - Else if match && level!=0: load=1 and data_out=head on the next edge, pop, stay in RUN.
    - Else if match && level==0: underrun=1 for one cycle, go to STARVE.
  - STARVE:
    - If !enable: go to IDLE.
    - Else if level!=0: load=1 and data_out=head on the next edge, pop, go to RUN. Terminal match is not awaited.
- Output timing:
  - load is high for exactly one cycle per pop; never on consecutive cycles.
  - data_out holds its last loaded value when load=0.
- Latency:
  - The counter shows term in cycle N; load=1 in cycle N+1, during which the counter shows term+1 (mod 2^WIDTH).
  - The counter shows the new preset in cycle N+2.
- Arithmetic and boundaries:
  - Comparison is unsigned and full width.
  - A preset equal to term triggers the next reload immediately after it loads (cycle N+2 match).
- Full: in_ready=0; in_valid is ignored with no overflow or corruption.
- Empty: no load is issued.
- Reset mid-operation: load drops immediately (asynchronously) and all queued entries are lost.

Decomposition:
- Shared package: FSM state enum (IDLE, RUN, STARVE) and the default WIDTH/DEPTH constants, reused by the counter bench.
- One sub-module: preset_fifo, a synchronous FIFO with push/pop, full/empty and level outputs.
- load_sequencer contains the FSM, the compare and the output registers.

Test Plan:
- Reset, term=15, enable=1, push 4'd4:
  - load=1 for exactly 1 cycle with data_out=4'd4; level returns to 0.
  - A counter model then shows q=4.
- Push presets 4 and 10, term=7, counter model attached:
  - q sequence 4,5,6,7,8,10.
  - load asserted in the cycle q=8, with data_out=10.
- Push one preset 4, term=7:
  - After q=7, underrun=1 for 1 cycle and the counter continues 8,9.
  - Then push 2: load=1 with data_out=2 on the cycle after level=1; q becomes 2.
- enable=0, push 5 values 1,2,3,4,5:
  - After the 4th push, level=4 and in_ready=0; the 5th value is not accepted.
  - Then enable=1: loads emerge 1,2,3,4 in order at successive term matches.
- Drive rst=0 mid-cycle while load=1:
  - load=0 immediately and level=0.
  - After release with enable=1 and no pushes, no load and no underrun for 20 cycles.
- In RUN, deassert enable, then drive q=term with level=2:
  - No load, no underrun, level stays 2, state is IDLE.
